// File: rtl/axis_axil_writer.sv
// Stream-to-AXI-lite writer: each AXI-stream word becomes one AXI-lite single write at a
// running byte address. Each frame starts at start_addr, and only one write is outstanding.
module axis_axil_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  output logic [ADDR_WIDTH-1:0]    m_axil_awaddr,
  output logic [2:0]               m_axil_awprot,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [DATA_WIDTH-1:0]    m_axil_wdata,
  output logic [STRB_WIDTH-1:0]    m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [1:0]               m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic                     frame_done,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  // state | meaning
  // IDLE  | stream ready, waiting for the next word
  // WRITE | AW and W offered, each drops after its own handshake
  // RESP  | both handshakes done, waiting for the B response
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RESP = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic                     tready_q, tready_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     frame_done_q, frame_done_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]    run_addr_q, run_addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     last_q, last_d;
  logic                     first_q, first_d;

  always_comb begin
    state_d      = state_q;
    tready_d     = tready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    addr_d       = addr_q;
    run_addr_d   = run_addr_q;
    data_d       = data_q;
    last_d       = last_q;
    first_d      = first_q;
    case (state_q)
      IDLE: begin
        tready_d = 1'b1;
        if (s_axis_tvalid && tready_q) begin
          data_d    = s_axis_tdata;
          last_d    = s_axis_tlast;
          addr_d    = first_q ? start_addr : run_addr_q;
          first_d   = 1'b0;
          tready_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready) wvalid_d = 1'b0;
        // A channel counts as done if it completed earlier or completes on this edge.
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (m_axil_bvalid && bready_q) begin
          bready_d     = 1'b0;
          tready_d     = 1'b1;
          state_d      = IDLE;
          run_addr_d   = addr_q + ADDR_WIDTH'(STRB_WIDTH);
          frame_done_d = last_q;
          first_d      = last_q;
          if (m_axil_bresp != 2'b00 && err_q != {ERR_CNT_WIDTH{1'b1}})
            err_d = err_q + ERR_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
      addr_q       <= '0;
      run_addr_q   <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      run_addr_q   <= run_addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      first_q      <= first_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = {STRB_WIDTH{1'b1}};
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign frame_done     = frame_done_q;
  assign err_count      = err_q;

endmodule
